// File: rtl/uart_tx_piso_if.sv
// uart_tx_piso_if: config, request and serial-line bundle for the
// UART parallel-in/serial-out transmit stage.
interface uart_tx_piso_if;
  logic        baud_tick;
  logic        send;
  logic [11:0] frame_in;
  logic        data_length;
  logic        stop_bits;
  logic [1:0]  parity_type;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    output baud_tick,
    output send,
    output frame_in,
    output data_length,
    output stop_bits,
    output parity_type,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  baud_tick,
    input  send,
    input  frame_in,
    input  data_length,
    input  stop_bits,
    input  parity_type,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx_piso.sv
// uart_tx_piso: captures a right-aligned 9..12 bit frame and shifts it
// out MSB-first, one bit per baud tick, ending with a done pulse.
module uart_tx_piso (
  input logic            clk,
  input logic            rst,
  uart_tx_piso_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [11:0] shreg;
  logic [11:0] shreg_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [3:0]  len;
  logic [3:0]  pad;
  logic        par;
  logic        tx_q;
  logic        tx_n;
  logic        busy_q;
  logic        busy_n;
  logic        done_q;
  logic        done_n;

  // 01 and 10 carry a parity bit, 00 and 11 do not
  assign par = bus.parity_type[1] ^ bus.parity_type[0];

  assign len = 4'd9
             + {3'd0, bus.data_length}
             + {3'd0, par}
             + {3'd0, bus.stop_bits};

  assign pad = 4'd12 - len;

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= 12'hFFF;
      cnt    <= 4'd0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      cnt    <= cnt_n;
      tx_q   <= tx_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (bus.send) begin
          // left-justify so the start bit sits at shreg[11]
          shreg_n = bus.frame_in << pad;
          cnt_n   = len;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.baud_tick) begin
          if (cnt != 4'd0) begin
            tx_n    = shreg[11];
            shreg_n = {shreg[10:0], 1'b1};
            cnt_n   = cnt - 4'd1;
          end else begin
            // last bit has now been on the line a full period
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_piso.sv
// tb_uart_tx_piso: table vectors, corner sequences and random frames
// checked against a bit-order model of the transmit stage.
module tb_uart_tx_piso;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   gap;

  uart_tx_piso_if bus ();

  uart_tx_piso dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] frame;
    logic        dl;
    logic        sb;
    logic [1:0]  pt;
    int          len;
    logic [11:0] bits;
  } vec_t;

  vec_t vecs [5];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int model_len(input logic dl, input logic sb,
                                   input logic [1:0] pt);
    int n;
    n = 1 + (dl ? 8 : 7) + (sb ? 2 : 1);
    if (pt == 2'b01 || pt == 2'b10) n = n + 1;
    return n;
  endfunction

  // line order left-justified: k-th bit sent is s[12-k]
  function automatic logic [11:0] model_seq(input logic [11:0] f,
                                            input int n);
    logic [11:0] s;
    s = '1;
    for (int k = 1; k <= n; k++) s[12-k] = f[n-k];
    return s;
  endfunction

  task automatic set_cfg(input logic [11:0] f, input logic dl,
                         input logic sb, input logic [1:0] pt);
    bus.frame_in    = f;
    bus.data_length = dl;
    bus.stop_bits   = sb;
    bus.parity_type = pt;
  endtask

  task automatic run_frame(input logic [11:0] f, input logic dl,
                           input logic sb, input logic [1:0] pt,
                           input int n, input logic [11:0] exp,
                           input bit inj, input bit coinc);
    logic last;
    set_cfg(f, dl, sb, pt);
    bus.send      = 1'b1;
    bus.baud_tick = coinc;
    cyc();
    bus.send      = 1'b0;
    bus.baud_tick = 1'b0;
    chk("busy_rise", bus.busy, 1);
    chk("tx_idle_at_accept", bus.tx, 1);
    last = 1'b1;
    for (int k = 1; k <= n + 1; k++) begin
      for (int g = 0; g < gap; g++) begin
        if (inj && k == 5 && g == 0) begin
          bus.send        = 1'b1;
          bus.frame_in    = ~f;
          bus.data_length = ~dl;
          bus.stop_bits   = ~sb;
        end
        cyc();
        bus.send = 1'b0;
        chk("hold_tx", bus.tx, last);
        chk("hold_done", bus.done, 0);
        chk("hold_busy", bus.busy, 1);
      end
      bus.baud_tick = 1'b1;
      cyc();
      bus.baud_tick = 1'b0;
      if (k <= n) begin
        chk("tx_bit", bus.tx, exp[12-k]);
        chk("busy_mid", bus.busy, 1);
        chk("done_early", bus.done, 0);
        last = exp[12-k];
      end else begin
        chk("done_pulse", bus.done, 1);
        chk("busy_fall", bus.busy, 0);
        chk("tx_idle_end", bus.tx, 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      bus.baud_tick = (i == 1);
      cyc();
      chk("done_single", bus.done, 0);
      chk("no_second_frame", bus.busy, 0);
      chk("tx_idle_after", bus.tx, 1);
    end
    bus.baud_tick = 1'b0;
  endtask

  task automatic tick_once();
    for (int g = 0; g < gap; g++) cyc();
    bus.baud_tick = 1'b1;
    cyc();
    bus.baud_tick = 1'b0;
  endtask

  initial begin
    logic [11:0] f;
    logic        dl;
    logic        sb;
    logic [1:0]  pt;
    logic        expb;
    int          n;
    int          dones;

    checks = 0;
    errors = 0;
    gap    = 3;
    rst    = 1'b0;
    bus.baud_tick = 1'b0;
    bus.send      = 1'b0;
    set_cfg(12'h000, 1'b0, 1'b0, 2'b00);

    vecs[0] = '{12'h297, 1'b1, 1'b0, 2'b01, 11, 12'h52E};
    vecs[1] = '{12'h001, 1'b0, 1'b0, 2'b00,  9, 12'h008};
    vecs[2] = '{12'h7FB, 1'b1, 1'b1, 2'b10, 12, 12'h7FB};
    vecs[3] = '{12'h5A3, 1'b0, 1'b1, 2'b01, 11, 12'hB46};
    vecs[4] = '{12'hC55, 1'b0, 1'b1, 2'b11, 10, 12'h154};

    cyc();
    cyc();
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b1;
    cyc();
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_tx", bus.tx, 1);

    foreach (vecs[i])
      run_frame(vecs[i].frame, vecs[i].dl, vecs[i].sb, vecs[i].pt,
                vecs[i].len, vecs[i].bits, 1'b0, 1'b0);

    // request while busy with a different frame, then tick at accept
    run_frame(12'h297, 1'b1, 1'b0, 2'b01, 11, 12'h52E, 1'b1, 1'b0);
    run_frame(12'h7FB, 1'b1, 1'b1, 2'b10, 12, 12'h7FB, 1'b0, 1'b1);

    // asynchronous reset after tick 4 of an all-zero frame
    set_cfg(12'h001, 1'b0, 1'b0, 2'b00);
    bus.send = 1'b1;
    cyc();
    bus.send = 1'b0;
    for (int k = 0; k < 4; k++) tick_once();
    chk("pre_rst_tx", bus.tx, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx", bus.tx, 1);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_done", bus.done, 0);
    dones = 0;
    for (int k = 0; k < 2; k++) begin
      tick_once();
      dones += int'(bus.done);
    end
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick_once();
      dones += int'(bus.done);
      chk("rst_abandon_busy", bus.busy, 0);
    end
    chk("rst_no_done", dones, 0);
    run_frame(12'h001, 1'b0, 1'b0, 2'b00, 9, 12'h008, 1'b0, 1'b0);

    // send held high: two frames with one idle-high period between
    set_cfg(12'h297, 1'b1, 1'b0, 2'b01);
    bus.send = 1'b1;
    cyc();
    dones = 0;
    for (int t = 1; t <= 24; t++) begin
      for (int g = 0; g < gap; g++) begin
        cyc();
        dones += int'(bus.done);
        if (t == 13 && g == 0) chk("b2b_rebusy", bus.busy, 1);
      end
      bus.baud_tick = 1'b1;
      cyc();
      bus.baud_tick = 1'b0;
      dones += int'(bus.done);
      if (t == 13) bus.send = 1'b0;
      if (t == 12 || t == 24) expb = 1'b1;
      else if (t < 12) expb = vecs[0].bits[12-t];
      else expb = vecs[0].bits[24-t];
      chk("b2b_tx", bus.tx, expb);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      dones += int'(bus.done);
    end
    chk("b2b_done_count", dones, 2);
    chk("b2b_idle", bus.busy, 0);

    for (int r = 0; r < 40; r++) begin
      f   = 12'($urandom);
      dl  = 1'($urandom);
      sb  = 1'($urandom);
      pt  = 2'($urandom);
      gap = $urandom_range(0, 3);
      n   = model_len(dl, sb, pt);
      run_frame(f, dl, sb, pt, n, model_seq(f, n), 1'b0,
                1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
